// File: rtl/mul_reconstruct_seq.sv
// Rebuilds a dividend from divider outputs as q*m + r using an LSB-first
// shift-add multiplier followed by a single remainder-add cycle.
module mul_reconstruct_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dividend,
  output logic               rem_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ADD_R = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Acceptance only from IDLE, so a start seen while busy or in DONE is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (cnt == CW'(1)) state_nxt = ADD_R;
      ADD_R:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mcand holds m << bit_index; q_sh shifts so bit 0 is always the current q bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh     <= '0;
      m_reg    <= '0;
      r_reg    <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dividend <= '0;
      rem_err  <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == ADD_R);
      case (state)
        IDLE: begin
          if (start) begin
            q_sh  <= q;
            m_reg <= m;
            r_reg <= r;
            mcand <= {{WIDTH{1'b0}}, m};
            acc   <= '0;
            cnt   <= CW'(WIDTH);
          end
        end
        MUL: begin
          if (q_sh[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          q_sh  <= q_sh >> 1;
          cnt   <= cnt - CW'(1);
        end
        ADD_R: begin
          // Outputs are only written here, so they hold until the next completion.
          acc      <= acc + {{WIDTH{1'b0}}, r_reg};
          dividend <= acc + {{WIDTH{1'b0}}, r_reg};
          rem_err  <= (m_reg == '0) || (r_reg >= m_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_reconstruct_seq.sv
// Randomized and directed bench for mul_reconstruct_seq; a scoreboard queue is
// filled at issue time and drained by a monitor whenever done is seen.
module tb_mul_reconstruct_seq;

  localparam int W   = 4;
  localparam int LAT = W + 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   q, m, r;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dividend;
  logic           rem_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2*W:0] exp_q[$];   // {rem_err, dividend}
  int           lat_q[$];   // cycle count at the negedge where start was driven

  mul_reconstruct_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q), .m(m), .r(r),
    .busy(busy), .done(done), .dividend(dividend), .rem_err(rem_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on the operands as latched
  function automatic logic [2*W:0] model(input int qq, input int mm, input int rr);
    int  val;
    logic err;
    val = qq * mm + rr;
    err = (mm == 0) || (rr >= mm);
    return {err, val[2*W-1:0]};
  endfunction

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Issues one operation and returns at the negedge after acceptance with
  // start low and the operand inputs scrambled.
  task automatic issue(input logic [W-1:0] qi, input logic [W-1:0] mi,
                       input logic [W-1:0] ri, input logic [2*W:0] expv);
    wait_idle();
    start = 1'b1;
    q = qi; m = mi; r = ri;
    exp_q.push_back(expv);
    lat_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    q = W'($urandom); m = W'($urandom); r = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 1, 0);
  endtask

  // scoreboard monitor
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    logic [2*W:0] e;
    int           t0;
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (prev_done) chk("done_single_cycle", 1, 0);
        else if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e  = exp_q.pop_front();
          t0 = lat_q.pop_front();
          chk("dividend", int'(dividend), int'(e[2*W-1:0]));
          chk("rem_err", int'(rem_err), int'(e[2*W]));
          chk("latency", cyc - t0, LAT);
        end
      end
      prev_done = done;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_length", busy_run, LAT);
        busy_run = 0;
      end
    end
  end

  int order[4096];

  initial begin
    int tmp, j, n;
    rst_n = 1'b0; start = 1'b0; q = '0; m = '0; r = '0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dividend", int'(dividend), 0);
    chk("rst_rem_err", int'(rem_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
    end

    // directed vectors with expected values written out
    issue(4'd13, 4'd7,  4'd3,  {1'b0, 8'd94});
    issue(4'd15, 4'd15, 4'd14, {1'b0, 8'd239});
    issue(4'd0,  4'd9,  4'd5,  {1'b0, 8'd5});
    issue(4'd3,  4'd0,  4'd2,  {1'b1, 8'd2});
    issue(4'd1,  4'd4,  4'd4,  {1'b1, 8'd8});

    // starts during MUL and during DONE must be dropped
    issue(4'd9, 4'd5, 4'd2, {1'b0, 8'd47});
    start = 1'b1; q = 4'd15; m = 4'd15; r = 4'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; q = 4'd14; m = 4'd11; r = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", int'(busy), 0);

    // reset during the 3rd MUL cycle, then a fresh operation
    issue(4'd11, 4'd13, 4'd6, {1'b0, 8'd149});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dividend", int'(dividend), 0);
    chk("abort_rem_err", int'(rem_err), 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_abort_done", int'(done), 0);
    end
    issue(4'd5, 4'd6, 4'd1, {1'b0, 8'd31});

    // every (q, m, r) triple in shuffled order
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = order[i][11:0];
      issue(v[11:8], v[7:4], v[3:0], model(v[11:8], v[7:4], v[3:0]));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_reconstruct_seq.md
MUL_RECONSTRUCT_SEQ -- requirements
Module: mul_reconstruct_seq

Interface
REQ-001 The block SHALL have parameter: WIDTH, 4, operand width of quotient, divisor and remainder.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: start  input  1  request pulse, operands sampled when accepted.
REQ-005 The block SHALL have port: q  input  WIDTH  quotient from divider (multiplier operand).
REQ-006 The block SHALL have port: m  input  WIDTH  divisor (multiplicand operand).
REQ-007 The block SHALL have port: r  input  WIDTH  corrected remainder, added after the multiply.
REQ-008 The block SHALL have port: busy  output  1  high from acceptance cycle through the DONE cycle.
REQ-009 The block SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 The block SHALL have port: dividend  output  2*WIDTH  reconstructed value q*m + r.
REQ-011 The block SHALL have port: rem_err  output  1  operand check flag, valid with done.

Function
REQ-012 The block SHALL recompute the dividend from divider outputs as q*m + r, unsigned, using sequential shift-add, one multiplier bit per cycle.
REQ-013 The FSM SHALL have states IDLE, MUL, ADD_R, DONE; encoding is free.
REQ-014 In IDLE with start=1, the block SHALL latch q, m and r into internal registers, clear the accumulator, load the bit counter with WIDTH, and enter MUL.
REQ-015 In MUL, each cycle SHALL add (m << bit index) to the accumulator when the current q bit is 1, advance the index LSB-first, and decrement the counter.
REQ-016 The FSM SHALL leave MUL for ADD_R after exactly WIDTH MUL cycles.
REQ-017 In ADD_R, the block SHALL add r, zero-extended to 2*WIDTH, to the accumulator and enter DONE.
REQ-018 In DONE, the block SHALL assert done for exactly one cycle, update dividend and rem_err, and return to IDLE.
REQ-019 Latency SHALL be WIDTH+2 cycles from the start-accepting edge to the edge at which done is high: 6 cycles for WIDTH=4.
REQ-020 The accumulator SHALL be 2*WIDTH bits, and no overflow SHALL be possible, since max q*m + r < 2^(2*WIDTH) for r <= 2^WIDTH-1.
REQ-021 The block SHALL set rem_err=1 when m==0 or r>=m, evaluated on latched operands; dividend SHALL still be computed normally.
REQ-022 The block SHALL hold dividend and rem_err stable from DONE until the next DONE, so the output is not disturbed while a new operation runs.
REQ-023 start SHALL be ignored while busy=1, with no queuing; a start in the same cycle that DONE returns to IDLE SHALL also be ignored, so acceptance happens only when the state is IDLE.
REQ-024 Input changes on q, m and r after acceptance SHALL not affect the result.
REQ-025 busy SHALL be a registered output, high in MUL, ADD_R and DONE, and low in IDLE.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, regardless of clk, force the state to IDLE and set busy=0, done=0, dividend=0, rem_err=0, and clear the accumulator, counter and operand registers.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.
REQ-028 After rst_n is released, the block SHALL be in IDLE on the next clk edge with no spurious done.

Verification
REQ-029 The bench SHALL cover: WIDTH=4, q=13, m=7, r=3, start for 1 cycle -> done exactly 6 cycles later, dividend=94, rem_err=0, busy high for 6 cycles.
REQ-030 The bench SHALL cover: q=15, m=15, r=14 -> dividend=239, rem_err=0; q=0, m=9, r=5 -> dividend=5.
REQ-031 The bench SHALL cover: m=0, q=3, r=2 -> dividend=2, rem_err=1; m=4, r=4, q=1 -> dividend=8, rem_err=1.
REQ-032 The bench SHALL cover: a second start pulsed in the MUL and DONE cycles -> ignored, with only one done pulse, and dividend reflecting the first operands only.
REQ-033 The bench SHALL cover: rst_n pulsed low during the 3rd MUL cycle -> outputs 0 immediately and no done; a fresh start with q=5, m=6, r=1 -> dividend=31 after 6 cycles.
REQ-034 The bench SHALL cover: random sweep of all 4096 (q, m, r) triples with operands changed after acceptance -> dividend == q*m + r for the latched values, and rem_err matches (m==0 or r>=m).
